// File: rtl/md_rr_arbiter_pkg.sv
// Shared types and constants for the metadata (MD) stream blocks.
//   arb_state_e : arbiter grant state (IDLE, GNT1, GNT2)
//   SRC_MD1/2   : source tag carried on the merged stream's TUSER
//   MD_DW/MD_CW : default data width and packet-counter width
package md_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT1 = 2'd1,
    ST_GNT2 = 2'd2
  } arb_state_e;

  localparam logic SRC_MD1 = 1'b0;
  localparam logic SRC_MD2 = 1'b1;

  localparam int MD_DW = 512;
  localparam int MD_CW = 16;

endpackage

// File: rtl/md_rr_arbiter_if.sv
// AXI-stream style MD bus.
//   tdata/tlast : beat payload and end-of-packet marker
//   tuser       : source tag, only meaningful on a merged stream
//   tvalid      : producer has a beat
//   tready      : consumer can take a beat
// Handshake: a beat moves on a rising clock edge where tvalid and tready are
// both 1. Once tvalid is raised it stays high, with payload held stable,
// until that transfer happens. tready may change freely and never has to
// wait for tvalid.
// master : producer side (drives payload, tag and valid)
// slave  : untagged consumer side (tag is added by whoever merges streams)
interface md_rr_arbiter_if
  import md_rr_arbiter_pkg::*;
#(
  parameter int DW = MD_DW
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic          tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/md_rr_arbiter_skid.sv
// md_axis_skid: 2-entry register slice for MD streams.
//   in_data/in_valid/in_ready    : upstream side; in_ready is a flop (= not full)
//   out_data/out_valid/out_ready : downstream side; payload comes straight
//                                  from storage, so it is stable under stall
// A beat pushed in cycle t is visible at the output in cycle t+1. One push
// and one pop per cycle are allowed, giving full throughput with one entry
// occupied; the second entry absorbs the beat already in flight when the
// registered in_ready could not yet react to a stall.
module md_axis_skid #(
  parameter int W = 514
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         in_ready_q, in_ready_d;
  logic         push, pop;

  assign push      = in_valid & in_ready_q;
  assign pop       = (count_q != 2'd0) & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
    // Look at the post-update fill so a pop re-opens the input next cycle.
    in_ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: rtl/md_rr_arbiter.sv
// md_rr_arbiter: packet-level round-robin merge of two MD streams.
//   clk, resetn           : clock, asynchronous active-low reset
//   axis_in_md1/md2       : source streams (slave side)
//   axis_out_md           : merged stream; tuser = SRC_MD1 / SRC_MD2
//   PKT_CNT1/PKT_CNT2     : packets accepted per source, wrapping at 2^CW
//   dbg_state             : current grant state
// A grant is held from the first beat until the TLAST beat of that source is
// accepted; the other source then gets priority. Accepted beats go through a
// 2-entry skid slice, so output appears one cycle after input acceptance.
module md_rr_arbiter
  import md_rr_arbiter_pkg::*;
#(
  parameter int DW = MD_DW,
  parameter int CW = MD_CW
) (
  input  logic                 clk,
  input  logic                 resetn,
  md_rr_arbiter_if.slave       axis_in_md1,
  md_rr_arbiter_if.slave       axis_in_md2,
  md_rr_arbiter_if.master      axis_out_md,
  output logic [CW-1:0]        PKT_CNT1,
  output logic [CW-1:0]        PKT_CNT2,
  output arb_state_e           dbg_state
);

  arb_state_e    state_q, state_d;
  logic          pref_md2_q, pref_md2_d;   // 1: MD2 wins the next tie
  logic [CW-1:0] cnt1_q, cnt1_d;
  logic [CW-1:0] cnt2_q, cnt2_d;

  logic          skid_in_ready;
  logic          v1, v2, acc1, acc2, eop1, eop2;
  logic [DW+1:0] push_data, pop_data;

  assign v1 = axis_in_md1.tvalid;
  assign v2 = axis_in_md2.tvalid;

  // TREADY comes only from registered state, never from TVALID.
  assign axis_in_md1.tready = (state_q == ST_GNT1) & skid_in_ready;
  assign axis_in_md2.tready = (state_q == ST_GNT2) & skid_in_ready;

  assign acc1 = axis_in_md1.tready & v1;
  assign acc2 = axis_in_md2.tready & v2;
  assign eop1 = acc1 & axis_in_md1.tlast;
  assign eop2 = acc2 & axis_in_md2.tlast;

  always_comb begin
    if (state_q == ST_GNT2) begin
      push_data = {SRC_MD2, axis_in_md2.tlast, axis_in_md2.tdata};
    end else begin
      push_data = {SRC_MD1, axis_in_md1.tlast, axis_in_md1.tdata};
    end
  end

  always_comb begin
    state_d    = state_q;
    pref_md2_d = pref_md2_q;
    cnt1_d     = cnt1_q;
    cnt2_d     = cnt2_q;
    case (state_q)
      ST_IDLE: begin
        if (v1 && v2)  state_d = pref_md2_q ? ST_GNT2 : ST_GNT1;
        else if (v1)   state_d = ST_GNT1;
        else if (v2)   state_d = ST_GNT2;
      end
      ST_GNT1: begin
        if (eop1) begin
          pref_md2_d = 1'b1;
          cnt1_d     = cnt1_q + CW'(1);
          // Hand straight over to a waiting peer so packets run back-to-back.
          state_d    = v2 ? ST_GNT2 : (v1 ? ST_GNT1 : ST_IDLE);
        end
      end
      ST_GNT2: begin
        if (eop2) begin
          pref_md2_d = 1'b0;
          cnt2_d     = cnt2_q + CW'(1);
          state_d    = v1 ? ST_GNT1 : (v2 ? ST_GNT2 : ST_IDLE);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      pref_md2_q <= 1'b0;
      cnt1_q     <= '0;
      cnt2_q     <= '0;
    end else begin
      state_q    <= state_d;
      pref_md2_q <= pref_md2_d;
      cnt1_q     <= cnt1_d;
      cnt2_q     <= cnt2_d;
    end
  end

  md_axis_skid #(.W(DW + 2)) u_skid (
    .clk       (clk),
    .resetn    (resetn),
    .in_data   (push_data),
    .in_valid  (acc1 | acc2),
    .in_ready  (skid_in_ready),
    .out_data  (pop_data),
    .out_valid (axis_out_md.tvalid),
    .out_ready (axis_out_md.tready)
  );

  assign axis_out_md.tdata = pop_data[DW-1:0];
  assign axis_out_md.tlast = pop_data[DW];
  assign axis_out_md.tuser = pop_data[DW+1];

  assign PKT_CNT1  = cnt1_q;
  assign PKT_CNT2  = cnt2_q;
  assign dbg_state = state_q;

endmodule
